// File: rtl/seg7_multi_ctrl.sv
// Multi-digit 7-seg decoder with blink period counter and debounced push-button events.
// Optional build macro: SEG7_LEADING_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_multi_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int NUM_PUSH       = 4,
    parameter int PERIOD_W       = 28,
    parameter int PERIOD_DEFAULT = 25_000_000,
    parameter int DEB_CYCLES     = 50_000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [2:0]              addr,
    input  logic                    wr_en,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    input  logic [NUM_PUSH-1:0]     push_n,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [PERIOD_W-1:0]     period_out,
    output logic                    irq
);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam int HW    = 7 * NUM_DIGITS;
    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam logic [PERIOD_W-1:0] RELOAD_RST = PERIOD_W'(PERIOD_DEFAULT);
    localparam logic [DEB_W-1:0]    DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [DW-1:0]       digits_q, digits_d;
    logic [NUM_DIGITS-1:0] blink_q, blink_d;
    logic [PERIOD_W-1:0] reload_q, reload_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic                phase_q, phase_d;
    logic [HW-1:0]       hex_q, hex_d;
    logic [NUM_PUSH-1:0] evt_q, evt_d;
    logic [NUM_PUSH-1:0] mask_q, mask_d;
    logic                irq_q, irq_d;
    logic [NUM_PUSH-1:0] sync1_q, sync2_q;
    logic [NUM_PUSH-1:0] stable_q, stable_d;
    logic [DEB_W-1:0]    deb_cnt_q [NUM_PUSH];
    logic [DEB_W-1:0]    deb_cnt_d [NUM_PUSH];
    logic [NUM_PUSH-1:0] press, w1c;
    logic [NUM_DIGITS-1:0] lead_blank;
    logic                unused_wr;
`ifdef SEG7_LEADING_BLANK_EN
    logic                lead;
`endif

    assign unused_wr = ^wr_data;

    always_comb begin
        digits_d = digits_q;
        blink_d  = blink_q;
        reload_d = reload_q;
        mask_d   = mask_q;
        w1c      = '0;
        if (wr_en) begin
            case (addr)
                3'd0: digits_d = wr_data[DW-1:0];
                3'd1: blink_d  = wr_data[NUM_DIGITS-1:0];
                3'd2: reload_d = wr_data[PERIOD_W-1:0];
                3'd3: w1c      = wr_data[NUM_PUSH-1:0];
                3'd4: mask_d   = wr_data[NUM_PUSH-1:0];
                default: ;
            endcase
        end
    end

    // A RELOAD write restarts the count but leaves the blink phase alone.
    always_comb begin
        count_d = count_q - 1'b1;
        phase_d = phase_q;
        if (wr_en && addr == 3'd2) begin
            count_d = wr_data[PERIOD_W-1:0];
        end else if (reload_q == '0) begin
            count_d = '0;
            phase_d = 1'b0;
        end else if (count_q == '0) begin
            count_d = reload_q;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        lead_blank = '0;
`ifdef SEG7_LEADING_BLANK_EN
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (digits_q[4*i +: 4] != 4'h0) lead = 1'b0;
            lead_blank[i] = lead;
        end
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_d[7*i +: 7] = seg_decode(digits_q[4*i +: 4]);
            if (lead_blank[i] || (blink_q[i] && phase_q)) begin
                hex_d[7*i +: 7] = 7'h7F;
            end
        end
    end

    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        for (int j = 0; j < NUM_PUSH; j++) begin
            if (sync2_q[j] == stable_q[j]) begin
                deb_cnt_d[j] = '0;
            end else if (deb_cnt_q[j] == DEB_LAST) begin
                stable_d[j]  = sync2_q[j];
                deb_cnt_d[j] = '0;
            end else begin
                deb_cnt_d[j] = deb_cnt_q[j] + 1'b1;
            end
        end
        // Set has priority over a same-cycle W1C of the same bit.
        press = stable_q & ~stable_d;
        evt_d = (evt_q & ~w1c) | press;
        irq_d = |(evt_q & mask_q);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            digits_q <= '0;
            blink_q  <= '0;
            reload_q <= RELOAD_RST;
            count_q  <= RELOAD_RST;
            phase_q  <= 1'b0;
            hex_q    <= '1;
            evt_q    <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            for (int j = 0; j < NUM_PUSH; j++) deb_cnt_q[j] <= '0;
        end else begin
            digits_q  <= digits_d;
            blink_q   <= blink_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            phase_q   <= phase_d;
            hex_q     <= hex_d;
            evt_q     <= evt_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            sync1_q   <= push_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            3'd0: rd_data[DW-1:0]         = digits_q;
            3'd1: rd_data[NUM_DIGITS-1:0] = blink_q;
            3'd2: rd_data[PERIOD_W-1:0]   = reload_q;
            3'd3: rd_data[NUM_PUSH-1:0]   = evt_q;
            3'd4: rd_data[NUM_PUSH-1:0]   = mask_q;
            default: ;
        endcase
    end

    assign hex_out    = hex_q;
    assign period_out = count_q;
    assign irq        = irq_q;
endmodule
